main_fsm_controller: RTL and testbench
======================================

// Module: main_fsm_controller
// PURPOSE
//  Multicycle sequencer for the ARM-subset datapath. Walks each instruction through
//  fetch/decode/execute/memory/writeback states and drives the datapath mux selects.
//  Its RegW, MemW and Branch outputs feed the conditional-logic block, which gates them with CondEx.
//  Also keeps a retired-instruction counter for debug.
// PARAMETERS
//  CNT_W  32  width of InstrCount (retired-instruction counter)
// PORTS
//  clk         in   1      system clock; single clock domain
//  reset       in   1      synchronous, active-high
//  Op          in   2      instr[27:26]: 00 DP, 01 MEM, 10 B, 11 illegal
//  Funct       in   6      instr[25:20]: Funct[5]=I (immediate), Funct[0]=S/L (set flags / load)
//  MemReady    in   1      memory done; present only with MAINFSM_MEMWAIT_EN
//  IRWrite     out  1      load instruction register
//  NextPC      out  1      PC write enable (unconditional)
//  AdrSrc      out  1      0 = PC, 1 = ALUResult as memory address
//  ALUSrcA     out  2      00 = RD1, 01 = PC
//  ALUSrcB     out  2      00 = RD2, 01 = ExtImm, 10 = const 4
//  ResultSrc   out  2      00 = ALUOut, 01 = Data, 10 = ALUResult
//  ALUOp       out  1      1 = ALU decoder uses Funct; 0 = add
//  RegW        out  1      register write request (pre-CondEx)
//  MemW        out  1      memory write request (pre-CondEx)
//  Branch      out  1      branch request (pre-CondEx)
//  State       out  4      current state, debug
//  InstrCount  out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  - Moore FSM. Outputs are combinational from State only. Unlisted outputs are 0.
//    FETCH(0):  IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10
//    DECODE(1): ALUSrcA=01, ALUSrcB=10, ResultSrc=10
//    MEMADR(2): ALUSrcA=00, ALUSrcB=01
//    MEMRD(3):  AdrSrc=1, ResultSrc=00
//    MEMWB(4):  ResultSrc=01, RegW=1
//    MEMWR(5):  AdrSrc=1, ResultSrc=00, MemW=1
//    EXECR(6):  ALUSrcA=00, ALUSrcB=00, ALUOp=1
//    EXECI(7):  ALUSrcA=00, ALUSrcB=01, ALUOp=1
//    ALUWB(8):  ResultSrc=00, RegW=1
//    BRANCH(9): ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1
//  - Transitions:
//    FETCH -> DECODE.
//    DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR, with Funct[5]=1 -> EXECI;
//            Op=10 -> BRANCH; Op=11 -> FETCH (NOP, not counted).
//    MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
//    MEMRD -> MEMWB. EXECR/EXECI -> ALUWB.
//    MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
//    Encodings 10..15 -> FETCH next cycle with all outputs 0.
//  - Latency, FETCH entry to FETCH re-entry: DP 4 cycles, LDR 5, STR 4, B 3, illegal 2.
//  - InstrCount increments by 1 on each transition MEMWB/MEMWR/ALUWB/BRANCH -> FETCH.
//    Wraps from 2^CNT_W-1 to 0. Counts regardless of CondEx.
//  - Reset: on a clock edge with reset=1, State <= FETCH and InstrCount <= 0. This applies mid-instruction too.
//    While reset=1, IRWrite, NextPC, RegW, MemW and Branch are forced to 0.
//    Normal FETCH outputs resume on the first cycle with reset=0.
// CONFIGURATION
//  MAINFSM_MEMWAIT_EN defined:
//   - The MemReady port exists.
//   - FETCH, MEMRD and MEMWR hold their state while MemReady=0.
//   - In FETCH, IRWrite and NextPC are asserted only in the cycle MemReady=1, so the PC advances exactly once.
//   - MemW stays high throughout MEMWR until MemReady=1.
//   - reset overrides any wait.
//  Undefined: the MemReady port is absent; behaviour is identical to MemReady tied to 1.
// STRUCTURE
//  - Package main_fsm_pkg holds:
//    - statetype_t enum (4-bit, values above);
//    - OP_DP/OP_MEM/OP_B/OP_ILL constants;
//    - ALUSRCA_*, ALUSRCB_*, RESSRC_* encodings.
//  - Sub-module main_fsm_decoder: pure combinational map State -> output vector.
//  - The top level holds the state register, next-state logic and counter.
// TESTING
//  1 ADD reg (Op=00, Funct=000000): states 0,1,6,8,0; RegW=1 only in ALUWB; InstrCount 0 -> 1.
//  2 LDR (Op=01, Funct[0]=1) then STR (Funct[0]=0): 0,1,2,3,4,0 then 0,1,2,5,0;
//    MemW=1 only in MEMWR; count = 2.
//  3 B (Op=10): 0,1,9,0, Branch=1 for one cycle.
//    Op=11: 0,1,0, count unchanged.
//  4 reset asserted in MEMRD: next state FETCH, InstrCount=0, write enables 0 while reset high.
//  5 Preload InstrCount near max (CNT_W=4): 16th retire wraps 15 -> 0.
//  6 [MEMWAIT_EN] MemReady=0 for 3 cycles in FETCH: State holds 0, IRWrite/NextPC stay 0,
//    then pulse once when MemReady=1.
//    MEMWR with MemReady=0 for 2 cycles: MemW high for 3 cycles.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared types and encodings for the multicycle main FSM controller.
// Used by main_fsm_decoder and main_fsm_controller.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } statetype_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] ALUSRCA_RD1 = 2'b00;
  localparam logic [1:0] ALUSRCA_PC  = 2'b01;

  localparam logic [1:0] ALUSRCB_RD2    = 2'b00;
  localparam logic [1:0] ALUSRCB_EXTIMM = 2'b01;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b10;

  localparam logic [1:0] RESSRC_ALUOUT    = 2'b00;
  localparam logic [1:0] RESSRC_DATA      = 2'b01;
  localparam logic [1:0] RESSRC_ALURESULT = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

  // Final state of an instruction; leaving it for FETCH retires the instruction.
  function automatic logic is_retire_state(input statetype_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) || (s == S_BRANCH);
  endfunction

endpackage

// File: rtl/main_fsm_decoder.sv
// Pure combinational Moore output map: raw 4-bit state -> datapath control vector.
// Unused encodings (10..15) produce an all-zero vector.
module main_fsm_decoder
  import main_fsm_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.next_pc    = 1'b1;
        ctrl_o.alu_src_a  = ALUSRCA_PC;
        ctrl_o.alu_src_b  = ALUSRCB_FOUR;
        ctrl_o.result_src = RESSRC_ALURESULT;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a  = ALUSRCA_PC;
        ctrl_o.alu_src_b  = ALUSRCB_FOUR;
        ctrl_o.result_src = RESSRC_ALURESULT;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = ALUSRCA_RD1;
        ctrl_o.alu_src_b = ALUSRCB_EXTIMM;
      end
      S_MEMRD: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RESSRC_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RESSRC_DATA;
        ctrl_o.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RESSRC_ALUOUT;
        ctrl_o.mem_w      = 1'b1;
      end
      S_EXECR: begin
        ctrl_o.alu_src_a = ALUSRCA_RD1;
        ctrl_o.alu_src_b = ALUSRCB_RD2;
        ctrl_o.alu_op    = 1'b1;
      end
      S_EXECI: begin
        ctrl_o.alu_src_a = ALUSRCA_RD1;
        ctrl_o.alu_src_b = ALUSRCB_EXTIMM;
        ctrl_o.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RESSRC_ALUOUT;
        ctrl_o.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = ALUSRCA_RD1;
        ctrl_o.alu_src_b  = ALUSRCB_EXTIMM;
        ctrl_o.result_src = RESSRC_ALURESULT;
        ctrl_o.branch     = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm_controller.sv
// Multicycle main FSM: state register, next-state logic and retired-instruction counter.
// Optional MAINFSM_MEMWAIT_EN adds MemReady and stalls FETCH/MEMRD/MEMWR until memory is done.
module main_fsm_controller
  import main_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
`ifdef MAINFSM_MEMWAIT_EN
  input  logic             MemReady,
`endif
  output logic             IRWrite,
  output logic             NextPC,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  statetype_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mem_ready;
  logic             retire;
  ctrl_t            ctrl;

`ifdef MAINFSM_MEMWAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  // Only I and S/L participate in sequencing; the ALU decoder consumes the rest.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_B:    state_d = S_BRANCH;
          OP_ILL:  state_d = S_FETCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_MEMWB:  state_d = S_FETCH;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  assign retire  = is_retire_state(state_q) && (state_d == S_FETCH);
  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  main_fsm_decoder u_decoder (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Enables are suppressed during reset; fetch strobes wait for the memory handshake.
  assign IRWrite    = ctrl.ir_write & mem_ready & ~reset;
  assign NextPC     = ctrl.next_pc  & mem_ready & ~reset;
  assign AdrSrc     = ctrl.adr_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ResultSrc  = ctrl.result_src;
  assign ALUOp      = ctrl.alu_op;
  assign RegW       = ctrl.reg_w  & ~reset;
  assign MemW       = ctrl.mem_w  & ~reset;
  assign Branch     = ctrl.branch & ~reset;
  assign State      = state_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_main_fsm_controller.sv
// Scoreboard bench for main_fsm_controller (CNT_W=4): directed per-cycle vectors push
// expected state/controls/count; a negedge monitor pops and compares.
module tb_main_fsm_controller;

  localparam int CNT_W = 4;
`ifdef MAINFSM_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [1:0]       op;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             ir_write, next_pc, adr_src, alu_op, reg_w, mem_w, branch;
  logic [1:0]       alu_src_a, alu_src_b, result_src;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  main_fsm_controller #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (op),
    .Funct      (funct),
`ifdef MAINFSM_MEMWAIT_EN
    .MemReady   (mem_ready),
`endif
    .IRWrite    (ir_write),
    .NextPC     (next_pc),
    .AdrSrc     (adr_src),
    .ALUSrcA    (alu_src_a),
    .ALUSrcB    (alu_src_b),
    .ResultSrc  (result_src),
    .ALUOp      (alu_op),
    .RegW       (reg_w),
    .MemW       (mem_w),
    .Branch     (branch),
    .State      (state),
    .InstrCount (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       st;
    logic [CNT_W-1:0] cnt;
    logic [12:0]      ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Spec output table, packed {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch}.
  function automatic logic [12:0] exp_ctrl(input logic [3:0] st, input logic rst, input logic mr);
    logic [12:0] v;
    logic        mr_eff;
    mr_eff = MEMWAIT ? mr : 1'b1;
    case (st)
      4'd0: v = 13'b1_1_0_01_10_10_0_0_0_0;
      4'd1: v = 13'b0_0_0_01_10_10_0_0_0_0;
      4'd2: v = 13'b0_0_0_00_01_00_0_0_0_0;
      4'd3: v = 13'b0_0_1_00_00_00_0_0_0_0;
      4'd4: v = 13'b0_0_0_00_00_01_0_1_0_0;
      4'd5: v = 13'b0_0_1_00_00_00_0_0_1_0;
      4'd6: v = 13'b0_0_0_00_00_00_1_0_0_0;
      4'd7: v = 13'b0_0_0_00_01_00_1_0_0_0;
      4'd8: v = 13'b0_0_0_00_00_00_0_1_0_0;
      4'd9: v = 13'b0_0_0_00_01_10_0_0_0_1;
      default: v = 13'b0;
    endcase
    v[12] = v[12] & mr_eff & ~rst;
    v[11] = v[11] & mr_eff & ~rst;
    v[2]  = v[2] & ~rst;
    v[1]  = v[1] & ~rst;
    v[0]  = v[0] & ~rst;
    return v;
  endfunction

  // One cycle: after the edge, apply inputs for the next edge and push this cycle's expectation.
  task automatic cyc(input logic r, input logic [1:0] o, input logic [5:0] f, input logic mr,
                     input logic [3:0] st, input logic [CNT_W-1:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = r;
    op        = o;
    funct     = f;
    mem_ready = mr;
    e.st      = st;
    e.cnt     = cnt;
    e.ctrl    = exp_ctrl(st, r, mr);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [12:0] act;
      e   = exp_q.pop_front();
      act = {ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
             alu_op, reg_w, mem_w, branch};
      txn++;
      checks += 3;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state txn=%0d got=%0d want=%0d", txn, state, e.st);
      end
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl txn=%0d state=%0d got=%b want=%b", txn, state, act, e.ctrl);
      end
      if (instr_count !== e.cnt) begin
        errors++;
        $display("FAIL count txn=%0d got=%0d want=%0d", txn, instr_count, e.cnt);
      end
      $display("txn=%0d reset=%0b state=%0d ctrl=%b count=%0d", txn, reset, state, act, instr_count);
    end
  end

  initial begin
    reset = 1'b1; op = 2'b00; funct = 6'b0; mem_ready = 1'b1;
    // reset edge: FETCH with fetch strobes forced low
    cyc(1, 2'b00, 6'b000000, 1, 4'd0, 0);
    // ADD reg: 0,1,6,8 -> count 1
    cyc(0, 2'b00, 6'b000000, 1, 4'd0, 0);
    cyc(0, 2'b00, 6'b000000, 1, 4'd1, 0);
    cyc(0, 2'b00, 6'b000000, 1, 4'd6, 0);
    cyc(0, 2'b00, 6'b000000, 1, 4'd8, 0);
    // LDR: 0,1,2,3,4
    cyc(0, 2'b01, 6'b000001, 1, 4'd0, 1);
    cyc(0, 2'b01, 6'b000001, 1, 4'd1, 1);
    cyc(0, 2'b01, 6'b000001, 1, 4'd2, 1);
    cyc(0, 2'b01, 6'b000001, 1, 4'd3, 1);
    cyc(0, 2'b01, 6'b000001, 1, 4'd4, 1);
    // STR: 0,1,2,5
    cyc(0, 2'b01, 6'b000000, 1, 4'd0, 2);
    cyc(0, 2'b01, 6'b000000, 1, 4'd1, 2);
    cyc(0, 2'b01, 6'b000000, 1, 4'd2, 2);
    cyc(0, 2'b01, 6'b000000, 1, 4'd5, 2);
    // B: 0,1,9
    cyc(0, 2'b10, 6'b000000, 1, 4'd0, 3);
    cyc(0, 2'b10, 6'b000000, 1, 4'd1, 3);
    cyc(0, 2'b10, 6'b000000, 1, 4'd9, 3);
    // illegal: 0,1 and no retire
    cyc(0, 2'b11, 6'b000000, 1, 4'd0, 4);
    cyc(0, 2'b11, 6'b000000, 1, 4'd1, 4);
    // DP immediate: 0,1,7,8
    cyc(0, 2'b00, 6'b100000, 1, 4'd0, 4);
    cyc(0, 2'b00, 6'b100000, 1, 4'd1, 4);
    cyc(0, 2'b00, 6'b100000, 1, 4'd7, 4);
    cyc(0, 2'b00, 6'b100000, 1, 4'd8, 4);
    // LDR interrupted by reset in MEMRD
    cyc(0, 2'b01, 6'b000001, 1, 4'd0, 5);
    cyc(0, 2'b01, 6'b000001, 1, 4'd1, 5);
    cyc(0, 2'b01, 6'b000001, 1, 4'd2, 5);
    cyc(1, 2'b01, 6'b000001, 1, 4'd3, 5);
    // 16 branches from count 0: wraps 15 -> 0
    for (int i = 0; i < 16; i++) begin
      cyc(0, 2'b10, 6'b000000, 1, 4'd0, CNT_W'(i));
      cyc(0, 2'b10, 6'b000000, 1, 4'd1, CNT_W'(i));
      cyc(0, 2'b10, 6'b000000, 1, 4'd9, CNT_W'(i));
    end
    cyc(0, 2'b00, 6'b000000, 1, 4'd0, 0);
`ifdef MAINFSM_MEMWAIT_EN
    cyc(0, 2'b00, 6'b000000, 1, 4'd1, 0);
    cyc(0, 2'b00, 6'b000000, 1, 4'd6, 0);
    cyc(0, 2'b00, 6'b000000, 1, 4'd8, 0);
    // FETCH stalled 3 cycles, then one strobe
    cyc(0, 2'b01, 6'b000000, 0, 4'd0, 1);
    cyc(0, 2'b01, 6'b000000, 0, 4'd0, 1);
    cyc(0, 2'b01, 6'b000000, 0, 4'd0, 1);
    cyc(0, 2'b01, 6'b000000, 1, 4'd0, 1);
    cyc(0, 2'b01, 6'b000000, 1, 4'd1, 1);
    cyc(0, 2'b01, 6'b000000, 1, 4'd2, 1);
    // MEMWR stalled 2 cycles: MemW high for 3
    cyc(0, 2'b01, 6'b000000, 0, 4'd5, 1);
    cyc(0, 2'b01, 6'b000000, 0, 4'd5, 1);
    cyc(0, 2'b01, 6'b000000, 1, 4'd5, 1);
    cyc(0, 2'b00, 6'b000000, 1, 4'd0, 2);
`endif
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
